bank_reg_file: RTL and testbench
================================

// Module: bank_reg_file
// PURPOSE
//  Owns the bank registers EB, FB, BB and the superbank bit (I/O channel 7) that drive
//  eBank/fBank/superBank into the address-translation logic. Sits beside the CPU write
//  and read path: decodes memory-mapped writes to addresses 3/4/6 and channel-7 writes,
//  and returns register-format read-back data.
//  Provides a one-deep save/restore slot for interrupt entry and exit.
// PARAMETERS
//  EB_ADDR     12'o0003  erasable bank register address
//  FB_ADDR     12'o0004  fixed bank register address
//  BB_ADDR     12'o0006  both-banks register address
//  SUPER_CHAN  9'o007    I/O channel holding the superbank bit
//  SUPER_BIT   6         bit of chanData carrying superbank
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high reset
//  wrEn        in   1   memory write strobe, one cycle
//  wrAddress   in   12  memory write address (pre-translation)
//  wrData      in   16  memory write data
//  rdEn        in   1   memory read strobe, one cycle
//  rdAddress   in   12  memory read address
//  rdData      out  16  read-back data, valid when rdValid
//  rdValid     out  1   1-cycle pulse; 1 cycle after rdEn when rdAddress hits EB/FB/BB
//  chanWrEn    in   1   I/O channel write strobe
//  chanAddr    in   9   I/O channel number
//  chanData    in   16  I/O channel write data
//  saveEn      in   1   interrupt entry: copy {fBank,eBank,superBank} to shadow
//  restoreEn   in   1   interrupt exit: load banks from shadow
//  eBank       out  3   current erasable bank
//  fBank       out  5   current fixed bank
//  superBank   out  1   current superbank bit
//  bankChange  out  1   1-cycle pulse the cycle after any of the three outputs changed value
// BEHAVIOUR
//  - Reset: eBank=0, fBank=0, superBank=0, shadow=0, rdData=0, rdValid=0, bankChange=0.
//  - Write EB: eBank<=wrData[10:8]. Write FB: fBank<=wrData[14:10].
//  - Write BB: fBank<=wrData[14:10] and eBank<=wrData[2:0]. Other bits ignored.
//  - Channel write with chanAddr==SUPER_CHAN: superBank<=chanData[SUPER_BIT]. Other channels ignored.
//  - Banks update on the edge where the strobe is sampled and are visible the next cycle.
//  - Read formats:
//      EB -> {5'b0,eBank,8'b0}
//      FB -> {1'b0,fBank,10'b0}
//      BB -> {1'b0,fBank,7'b0,eBank}
//    Latency is 1: rdData/rdValid register on the cycle after rdEn.
//    Read of any other address: rdValid=0, rdData holds its previous value.
//  - Read-during-write to the same register returns the OLD value (pre-write).
//  - Save captures the current (pre-write) banks, including when wrEn occurs in the same cycle.
//  - Priority per field, same cycle: wrEn/chanWrEn > restoreEn > hold.
//    restoreEn still loads fields that no write touches.
//  - saveEn and restoreEn in the same cycle: restore uses the old shadow; the shadow then takes the pre-update banks.
//  - wrEn and chanWrEn in the same cycle: both apply (disjoint fields).
//  - bankChange compares the registered outputs with their previous values.
//    Writing an identical value gives no pulse.
//  - reset mid-operation overrides every strobe that cycle; no pulse is produced by reset itself.
// STRUCTURE
//  - Shared include memConsts.vh: EB_ADDR, FB_ADDR, BB_ADDR, SUPER_CHAN, field bit positions.
//  - The address-translation block reuses the same include.
//  - Sub-module bank_readback_fmt: combinational address -> {hit, formatted word}.
//  - All other logic lives in the top module.
// TESTING
//  1. reset, wrEn addr 3 data 16'h0500 -> next cycle eBank=5; bankChange pulses once.
//  2. wrEn addr 6 data 16'h6C03 -> fBank=5'h1B, eBank=3.
//     Then rdEn addr 6 -> rdData=16'h6C03, rdValid 1 cycle.
//  3. chanWrEn chan 7 data 16'h0040 -> superBank=1.
//     Same write with chan 8 -> no change, no bankChange.
//  4. Banks fB=4, eB=2; saveEn; write FB=9 -> fBank=9.
//     restoreEn with a simultaneous EB write of 6 -> fBank=4, eBank=6.
//  5. rdEn + wrEn same cycle to addr 4 (old fBank=4, new data 16'h2800) -> rdData=16'h1000; fBank=10 next.
//  6. Assert reset during a wrEn to BB -> all outputs 0; rdEn addr 5 -> rdValid stays 0.

Source files
------------

// File: rtl/bank_reg_file_pkg.sv
// rtl/bank_reg_file_pkg.sv - shared addresses, field positions and bank types for the bank register file
package bank_reg_file_pkg;

    // Memory-mapped register addresses (pre-translation) and the superbank channel.
    localparam logic [11:0] EB_ADDR    = 12'o0003;
    localparam logic [11:0] FB_ADDR    = 12'o0004;
    localparam logic [11:0] BB_ADDR    = 12'o0006;
    localparam logic [8:0]  SUPER_CHAN = 9'o007;
    localparam int          SUPER_BIT  = 6;

    // Field widths and their bit positions in the register formats.
    localparam int EB_W      = 3;
    localparam int FB_W      = 5;
    localparam int EB_LSB    = 8;    // EB register: eBank in [10:8]
    localparam int FB_LSB    = 10;   // FB/BB register: fBank in [14:10]
    localparam int BB_EB_LSB = 0;    // BB register: eBank in [2:0]

    // Everything the interrupt shadow slot has to hold.
    typedef struct packed {
        logic [FB_W-1:0] f_bank;
        logic [EB_W-1:0] e_bank;
        logic            super_bank;
    } banks_t;

endpackage

// File: rtl/bank_readback_fmt.sv
// rtl/bank_readback_fmt.sv - combinational read address decode and register-format read-back word
//
// Ports:
//   addr   in   12  memory read address
//   e_bank in   3   current erasable bank
//   f_bank in   5   current fixed bank
//   hit    out  1   addr is EB, FB or BB
//   word   out  16  register-format value for addr (0 on a miss)
module bank_readback_fmt
    import bank_reg_file_pkg::*;
(
    input  logic [11:0]     addr,
    input  logic [EB_W-1:0] e_bank,
    input  logic [FB_W-1:0] f_bank,
    output logic            hit,
    output logic [15:0]     word
);

    always_comb begin
        hit  = 1'b0;
        word = 16'h0000;
        case (addr)
            EB_ADDR: begin
                hit  = 1'b1;
                word = {5'b0, e_bank, 8'b0};
            end
            FB_ADDR: begin
                hit  = 1'b1;
                word = {1'b0, f_bank, 10'b0};
            end
            BB_ADDR: begin
                hit  = 1'b1;
                word = {1'b0, f_bank, 7'b0, e_bank};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bank_reg_file.sv
// rtl/bank_reg_file.sv - EB/FB/BB bank registers, superbank bit, read-back and interrupt save/restore
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   wrEn, wrAddress, wrData          memory write strobe/address/data
//   rdEn, rdAddress, rdData, rdValid memory read strobe/address, registered read-back
//   chanWrEn, chanAddr, chanData     I/O channel write (channel 7 carries superbank)
//   saveEn, restoreEn                interrupt entry/exit shadow copy
//   eBank, fBank, superBank          current banks
//   bankChange                       pulse the cycle after any bank output changed
module bank_reg_file
    import bank_reg_file_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wrEn,
    input  logic [11:0]     wrAddress,
    input  logic [15:0]     wrData,
    input  logic            rdEn,
    input  logic [11:0]     rdAddress,
    output logic [15:0]     rdData,
    output logic            rdValid,
    input  logic            chanWrEn,
    input  logic [8:0]      chanAddr,
    input  logic [15:0]     chanData,
    input  logic            saveEn,
    input  logic            restoreEn,
    output logic [EB_W-1:0] eBank,
    output logic [FB_W-1:0] fBank,
    output logic            superBank,
    output logic            bankChange
);

    banks_t cur;
    banks_t nxt;
    banks_t shadow;
    banks_t prev;

    logic        rd_hit;
    logic [15:0] rd_word;

    logic wr_eb;
    logic wr_fb;
    logic wr_bb;
    logic wr_super;

    logic unused_bits;
    assign unused_bits = ^{wrData[15], wrData[7:3], chanData[15:7], chanData[5:0]};

    assign wr_eb    = wrEn && (wrAddress == EB_ADDR);
    assign wr_fb    = wrEn && (wrAddress == FB_ADDR);
    assign wr_bb    = wrEn && (wrAddress == BB_ADDR);
    assign wr_super = chanWrEn && (chanAddr == SUPER_CHAN);

    // Per-field priority: a write touching the field wins, otherwise a restore
    // reloads it from the shadow, otherwise it holds. Restore reads the shadow
    // before any same-cycle save overwrites it.
    always_comb begin
        nxt = cur;
        if (wr_eb) begin
            nxt.e_bank = wrData[EB_LSB +: EB_W];
        end else if (wr_bb) begin
            nxt.e_bank = wrData[BB_EB_LSB +: EB_W];
        end else if (restoreEn) begin
            nxt.e_bank = shadow.e_bank;
        end

        if (wr_fb || wr_bb) begin
            nxt.f_bank = wrData[FB_LSB +: FB_W];
        end else if (restoreEn) begin
            nxt.f_bank = shadow.f_bank;
        end

        if (wr_super) begin
            nxt.super_bank = chanData[SUPER_BIT];
        end else if (restoreEn) begin
            nxt.super_bank = shadow.super_bank;
        end
    end

    // Read-back is formatted from the pre-write registers, so a read and a
    // write to the same register in one cycle return the old value.
    bank_readback_fmt u_fmt (
        .addr   (rdAddress),
        .e_bank (cur.e_bank),
        .f_bank (cur.f_bank),
        .hit    (rd_hit),
        .word   (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            shadow     <= '0;
            prev       <= '0;
            rdData     <= 16'h0000;
            rdValid    <= 1'b0;
            bankChange <= 1'b0;
        end else begin
            cur <= nxt;
            if (saveEn) begin
                shadow <= cur;
            end
            // prev trails cur by one cycle, so the pulse lands the cycle after
            // the outputs took their new value. Reset clears both together,
            // which is why reset itself never produces a pulse.
            prev       <= cur;
            bankChange <= (cur != prev);
            rdValid    <= rdEn && rd_hit;
            if (rdEn && rd_hit) begin
                rdData <= rd_word;
            end
        end
    end

    assign eBank     = cur.e_bank;
    assign fBank     = cur.f_bank;
    assign superBank = cur.super_bank;

endmodule

// File: tb/tb_bank_reg_file.sv
// tb/tb_bank_reg_file.sv - self-checking directed bench for bank_reg_file
module tb_bank_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn;
    logic [11:0] wrAddress;
    logic [15:0] wrData;
    logic        rdEn;
    logic [11:0] rdAddress;
    logic [15:0] rdData;
    logic        rdValid;
    logic        chanWrEn;
    logic [8:0]  chanAddr;
    logic [15:0] chanData;
    logic        saveEn;
    logic        restoreEn;
    logic [2:0]  eBank;
    logic [4:0]  fBank;
    logic        superBank;
    logic        bankChange;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb_q[$];
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    bank_reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .wrEn       (wrEn),
        .wrAddress  (wrAddress),
        .wrData     (wrData),
        .rdEn       (rdEn),
        .rdAddress  (rdAddress),
        .rdData     (rdData),
        .rdValid    (rdValid),
        .chanWrEn   (chanWrEn),
        .chanAddr   (chanAddr),
        .chanData   (chanData),
        .saveEn     (saveEn),
        .restoreEn  (restoreEn),
        .eBank      (eBank),
        .fBank      (fBank),
        .superBank  (superBank),
        .bankChange (bankChange)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wrEn      = 1'b0;
        rdEn      = 1'b0;
        chanWrEn  = 1'b0;
        saveEn    = 1'b0;
        restoreEn = 1'b0;
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        idle();
    endtask

    // Read-back scoreboard: every rdValid pops the oldest expected word.
    always @(negedge clk) begin
        if (!reset && rdValid) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL rd_unexpected observed=%h expected=none", rdData);
            end
            if (sb_q.size() != 0) begin
                exp_word = sb_q.pop_front();
                check("rd_data", rdData, exp_word);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        wrAddress = '0;
        wrData    = '0;
        rdAddress = '0;
        chanAddr  = '0;
        chanData  = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        check("rst_ebank", 16'(eBank), 16'h0);
        check("rst_fbank", 16'(fBank), 16'h0);
        check("rst_super", 16'(superBank), 16'h0);
        check("rst_rdvalid", 16'(rdValid), 16'h0);
        check("rst_rddata", rdData, 16'h0);
        check("rst_bankchange", 16'(bankChange), 16'h0);

        // 1: EB write, bankChange one cycle after the new value shows.
        wrEn = 1'b1; wrAddress = 12'o0003; wrData = 16'h0500;
        step();
        check("t1_ebank", 16'(eBank), 16'h5);
        check("t1_bc_early", 16'(bankChange), 16'h0);
        tick();
        check("t1_bc_pulse", 16'(bankChange), 16'h1);
        tick();
        check("t1_bc_end", 16'(bankChange), 16'h0);

        // 2: BB write then BB read-back.
        wrEn = 1'b1; wrAddress = 12'o0006; wrData = 16'h6C03;
        step();
        check("t2_fbank", 16'(fBank), 16'h1B);
        check("t2_ebank", 16'(eBank), 16'h3);
        tick();
        rdEn = 1'b1; rdAddress = 12'o0006;
        sb_q.push_back(16'h6C03);
        step();
        check("t2_rdvalid", 16'(rdValid), 16'h1);
        tick();
        check("t2_rdvalid_end", 16'(rdValid), 16'h0);

        // 3: superbank via channel 7; channel 8 ignored.
        chanWrEn = 1'b1; chanAddr = 9'o007; chanData = 16'h0040;
        step();
        check("t3_super", 16'(superBank), 16'h1);
        tick();
        check("t3_bc", 16'(bankChange), 16'h1);
        chanWrEn = 1'b1; chanAddr = 9'o010; chanData = 16'h0000;
        step();
        check("t3_super_hold", 16'(superBank), 16'h1);
        check("t3_bc_none0", 16'(bankChange), 16'h0);
        tick();
        check("t3_bc_none1", 16'(bankChange), 16'h0);

        // 4: save fB=4 eB=2 sb=1, overwrite FB, restore with concurrent EB write.
        wrEn = 1'b1; wrAddress = 12'o0006; wrData = 16'h1002;
        step();
        check("t4_setup", {fBank, eBank}, 8'h22);
        saveEn = 1'b1;
        step();
        wrEn = 1'b1; wrAddress = 12'o0004; wrData = 16'h2400;
        step();
        check("t4_fbank9", 16'(fBank), 16'h9);
        chanWrEn = 1'b1; chanAddr = 9'o007; chanData = 16'h0000;
        step();
        check("t4_super0", 16'(superBank), 16'h0);
        restoreEn = 1'b1; wrEn = 1'b1; wrAddress = 12'o0003; wrData = 16'h0600;
        step();
        check("t4_rest_fbank", 16'(fBank), 16'h4);
        check("t4_rest_ebank", 16'(eBank), 16'h6);
        check("t4_rest_super", 16'(superBank), 16'h1);

        // Save in the same cycle as a write captures the pre-write banks.
        saveEn = 1'b1; wrEn = 1'b1; wrAddress = 12'o0004; wrData = 16'h1C00;
        step();
        check("t4b_fbank7", 16'(fBank), 16'h7);
        restoreEn = 1'b1;
        step();
        check("t4b_rest_fbank", 16'(fBank), 16'h4);
        check("t4b_rest_ebank", 16'(eBank), 16'h6);

        // Save and restore together: restore uses the old shadow (fB=4,eB=6).
        wrEn = 1'b1; wrAddress = 12'o0006; wrData = 16'h0401;
        step();
        saveEn = 1'b1; restoreEn = 1'b1;
        step();
        check("t4c_rest", {fBank, eBank}, 8'h26);
        restoreEn = 1'b1;
        step();
        check("t4c_shadow", {fBank, eBank}, 8'h09);
        wrEn = 1'b1; wrAddress = 12'o0006; wrData = 16'h1006;
        step();

        // 5: read-during-write on FB returns the old value.
        rdEn = 1'b1; rdAddress = 12'o0004;
        wrEn = 1'b1; wrAddress = 12'o0004; wrData = 16'h2800;
        sb_q.push_back(16'h1000);
        step();
        check("t5_rdvalid", 16'(rdValid), 16'h1);
        check("t5_fbank", 16'(fBank), 16'hA);
        rdEn = 1'b1; rdAddress = 12'o0003;
        sb_q.push_back(16'h0600);
        step();
        check("t5_eb_rdvalid", 16'(rdValid), 16'h1);
        tick();

        // 6: reset during a BB write; then a miss read.
        reset = 1'b1; wrEn = 1'b1; wrAddress = 12'o0006; wrData = 16'h7FFF;
        chanWrEn = 1'b1; chanAddr = 9'o007; chanData = 16'h0040;
        step();
        reset = 1'b0;
        check("t6_ebank", 16'(eBank), 16'h0);
        check("t6_fbank", 16'(fBank), 16'h0);
        check("t6_super", 16'(superBank), 16'h0);
        check("t6_rddata", rdData, 16'h0);
        tick();
        check("t6_bc", 16'(bankChange), 16'h0);
        rdEn = 1'b1; rdAddress = 12'o0005;
        step();
        check("t6_miss_valid", 16'(rdValid), 16'h0);
        check("t6_miss_data", rdData, 16'h0);
        tick();
        tick();

        check("sb_drained", 16'(sb_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
